blink_cmd_uart: RTL and testbench

//  Upstream stage of the LED blinker: receives remote config over UART (8N1)
//  and drives the blinker's on-time, off-time and enable registers.

---
 rtl/blink_cmd_uart.sv | 189 ++++++++++++++++++
 tb/tb_blink_cmd_uart.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_cmd_uart.sv
// UART (8N1) command receiver for the LED blinker: bit-level receiver feeding a
// 5-byte framed parser (A5, CMD, HI, LO, CHK) that owns the on/off/enable registers.
module blink_cmd_uart #(
   parameter int unsigned CLK_FREQ       = 25_000_000,
   parameter int unsigned BAUD           = 115_200,
   parameter int unsigned DEFAULT_ON_MS  = 900,
   parameter int unsigned DEFAULT_OFF_MS = 200,
   parameter int unsigned TIMEOUT_BITS   = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic [15:0] on_ms,
   output logic [15:0] off_ms,
   output logic        blink_en,
   output logic        cfg_valid,
   output logic        frame_err,
   output logic        cmd_err
);

   localparam int unsigned ClksPerBit  = CLK_FREQ / BAUD;
   localparam int unsigned CntW        = $clog2(ClksPerBit);
   localparam int unsigned TimeoutClks = TIMEOUT_BITS * ClksPerBit;
   localparam int unsigned TmoW        = $clog2(TimeoutClks + 1);

   localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(TimeoutClks - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {PSync, PCmd, PHi, PLo, PChk} p_state_e;

   logic            rx_meta_q, rx_sync_q;
   rx_state_e       rx_state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            stop_sample;
   logic            byte_valid;
   logic            bad_stop;

   p_state_e        p_state_q;
   logic [7:0]      cmd_q, hi_q, lo_q;
   logic [TmoW-1:0] tmo_q;
   logic [15:0]     val;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // The stop sample is decided combinationally so the parser acts on the same edge.
   assign stop_sample = (rx_state_q == RxStop) && (cnt_q == BitLast);
   assign byte_valid  = stop_sample && rx_sync_q;
   assign bad_stop    = stop_sample && !rx_sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q <= RxIdle;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         unique case (rx_state_q)
            RxIdle: begin
               cnt_q <= '0;
               if (!rx_sync_q) rx_state_q <= RxStart;
            end
            RxStart: begin
               if (cnt_q == HalfLast) begin
                  cnt_q      <= '0;
                  bit_idx_q  <= '0;
                  rx_state_q <= rx_sync_q ? RxIdle : RxData;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RxData: begin
               if (cnt_q == BitLast) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) rx_state_q <= RxStop;
                  else                   bit_idx_q  <= bit_idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RxStop: begin
               if (cnt_q == BitLast) begin
                  cnt_q      <= '0;
                  rx_state_q <= RxIdle;
                  frame_err  <= !rx_sync_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   assign val = {hi_q, lo_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_state_q <= PSync;
         cmd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         tmo_q     <= '0;
         on_ms     <= 16'(DEFAULT_ON_MS);
         off_ms    <= 16'(DEFAULT_OFF_MS);
         blink_en  <= 1'b1;
         cfg_valid <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cfg_valid <= 1'b0;
         cmd_err   <= 1'b0;
         if (bad_stop) begin
            p_state_q <= PSync;
            tmo_q     <= '0;
         end else if (byte_valid) begin
            tmo_q <= '0;
            case (p_state_q)
               PSync: if (shift_q == 8'hA5) p_state_q <= PCmd;
               PCmd: begin
                  cmd_q     <= shift_q;
                  p_state_q <= PHi;
               end
               PHi: begin
                  hi_q      <= shift_q;
                  p_state_q <= PLo;
               end
               PLo: begin
                  lo_q      <= shift_q;
                  p_state_q <= PChk;
               end
               PChk: begin
                  p_state_q <= PSync;
                  if (shift_q != (cmd_q ^ hi_q ^ lo_q)) begin
                     cmd_err <= 1'b1;
                  end else begin
                     case (cmd_q)
                        8'h01: begin
                           if (val == 16'd0) cmd_err <= 1'b1;
                           else begin
                              on_ms     <= val;
                              cfg_valid <= 1'b1;
                           end
                        end
                        8'h02: begin
                           if (val == 16'd0) cmd_err <= 1'b1;
                           else begin
                              off_ms    <= val;
                              cfg_valid <= 1'b1;
                           end
                        end
                        8'h03: begin
                           blink_en  <= lo_q[0];
                           cfg_valid <= 1'b1;
                        end
                        default: cmd_err <= 1'b1;
                     endcase
                  end
               end
               default: p_state_q <= PSync;
            endcase
         end else if (p_state_q != PSync) begin
            // Abandon a stalled frame silently.
            if (tmo_q == TmoLast) begin
               p_state_q <= PSync;
               tmo_q     <= '0;
            end else begin
               tmo_q <= tmo_q + 1'b1;
            end
         end else begin
            tmo_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_blink_cmd_uart.sv
// Directed bench for blink_cmd_uart at 10 clk per bit: serial frames in,
// register values and pulse counts checked against hand-computed results.
module tb_blink_cmd_uart;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic [15:0] on_ms, off_ms;
   logic        blink_en, cfg_valid, frame_err, cmd_err;

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0;
   int cfg_n = 0, cmd_n = 0, fe_n = 0, both_n = 0, wide_n = 0;
   int cfg_cyc = 0;
   int last_start = 0;
   logic cfg_p = 1'b0, cmd_p = 1'b0, fe_p = 1'b0;
   int cfg0, cmd0, fe0;

   blink_cmd_uart #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .on_ms    (on_ms),
      .off_ms   (off_ms),
      .blink_en (blink_en),
      .cfg_valid(cfg_valid),
      .frame_err(frame_err),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n) begin
         if (cfg_valid) begin
            cfg_n   = cfg_n + 1;
            cfg_cyc = cyc;
         end
         if (cmd_err)   cmd_n = cmd_n + 1;
         if (frame_err) fe_n  = fe_n + 1;
         if (cfg_valid && cmd_err) both_n = both_n + 1;
         if ((cfg_valid && cfg_p) || (cmd_err && cmd_p) || (frame_err && fe_p))
            wide_n = wide_n + 1;
      end
      cfg_p = cfg_valid;
      cmd_p = cmd_err;
      fe_p  = frame_err;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      last_start = cyc;
      uart_rx = 1'b0;
      idle(10);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(10);
      end
      uart_rx = stop;
      idle(10);
      uart_rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] k);
      send_byte(8'hA5, 1'b1);
      send_byte(c, 1'b1);
      send_byte(h, 1'b1);
      send_byte(l, 1'b1);
      send_byte(k, 1'b1);
   endtask

   task automatic snap();
      cfg0 = cfg_n;
      cmd0 = cmd_n;
      fe0  = fe_n;
   endtask

   initial begin
      idle(5);
      rst_n = 1'b1;

      // 1: reset values, quiet line
      idle(1000);
      check_eq("rst_on_ms", 32'(on_ms), 32'd900);
      check_eq("rst_off_ms", 32'(off_ms), 32'd200);
      check_eq("rst_blink_en", 32'(blink_en), 32'd1);
      check_eq("rst_no_pulses", 32'(cfg_n + cmd_n + fe_n), 32'd0);

      // 2: on_ms = 0x01F4
      snap();
      send_frame(8'h01, 8'h01, 8'hF4, 8'hF4);
      idle(20);
      check_eq("t2_on_ms", 32'(on_ms), 32'd500);
      check_eq("t2_off_ms", 32'(off_ms), 32'd200);
      check_eq("t2_cfg_cnt", 32'(cfg_n - cfg0), 32'd1);
      check_eq("t2_cmd_cnt", 32'(cmd_n - cmd0), 32'd0);
      // pulse must land inside the CHK byte's stop bit (clk 90..99 after its start edge)
      check_eq("t2_cfg_lat", 32'((cfg_cyc - last_start >= 89) && (cfg_cyc - last_start <= 101)),
               32'd1);

      // 3: bad checksum, then the good one (02^00^64 = 66)
      snap();
      send_frame(8'h02, 8'h00, 8'h64, 8'h00);
      idle(20);
      check_eq("t3_bad_cmd_err", 32'(cmd_n - cmd0), 32'd1);
      check_eq("t3_bad_cfg", 32'(cfg_n - cfg0), 32'd0);
      check_eq("t3_bad_off_ms", 32'(off_ms), 32'd200);
      snap();
      send_frame(8'h02, 8'h00, 8'h64, 8'h66);
      idle(20);
      check_eq("t3_off_ms", 32'(off_ms), 32'd100);
      check_eq("t3_cfg_cnt", 32'(cfg_n - cfg0), 32'd1);

      // 4: framing error on byte 2, then disable
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b0);
      idle(200);
      check_eq("t4_fe_cnt", 32'(fe_n - fe0), 32'd1);
      check_eq("t4_fe_no_cfg", 32'(cfg_n - cfg0), 32'd0);
      check_eq("t4_fe_no_cmd", 32'(cmd_n - cmd0), 32'd0);
      check_eq("t4_fe_on_ms", 32'(on_ms), 32'd500);
      snap();
      send_frame(8'h03, 8'h00, 8'h00, 8'h03);
      idle(20);
      check_eq("t4_blink_en", 32'(blink_en), 32'd0);
      check_eq("t4_cfg_cnt", 32'(cfg_n - cfg0), 32'd1);

      // 5: 3-clk glitch, then junk bytes and a zero on-period
      snap();
      @(negedge clk);
      uart_rx = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      idle(100);
      check_eq("t5_glitch_quiet", 32'(cfg_n - cfg0 + cmd_n - cmd0 + fe_n - fe0), 32'd0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_frame(8'h01, 8'h00, 8'h00, 8'h01);
      idle(20);
      check_eq("t5_zero_cmd_err", 32'(cmd_n - cmd0), 32'd1);
      check_eq("t5_zero_cfg", 32'(cfg_n - cfg0), 32'd0);
      check_eq("t5_on_ms", 32'(on_ms), 32'd500);

      // 6: inter-byte timeout drops the frame (would set on_ms=1000 otherwise)
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(250);
      send_byte(8'h03, 1'b1);
      send_byte(8'hE8, 1'b1);
      send_byte(8'hEA, 1'b1);
      idle(20);
      check_eq("t6_tmo_cfg", 32'(cfg_n - cfg0), 32'd0);
      check_eq("t6_tmo_cmd", 32'(cmd_n - cmd0), 32'd0);
      check_eq("t6_tmo_on_ms", 32'(on_ms), 32'd500);

      // 6b: reset mid-byte restores defaults; next frame accepted (02^00^32 = 30)
      @(negedge clk);
      uart_rx = 1'b0;
      idle(35);
      rst_n = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      rst_n = 1'b1;
      idle(5);
      check_eq("t6_rst_on_ms", 32'(on_ms), 32'd900);
      check_eq("t6_rst_off_ms", 32'(off_ms), 32'd200);
      check_eq("t6_rst_blink_en", 32'(blink_en), 32'd1);
      idle(200);
      snap();
      send_frame(8'h02, 8'h00, 8'h32, 8'h30);
      idle(20);
      check_eq("t6_post_off_ms", 32'(off_ms), 32'd50);
      check_eq("t6_post_cfg", 32'(cfg_n - cfg0), 32'd1);

      check_eq("pulse_overlap", 32'(both_n), 32'd0);
      check_eq("pulse_width", 32'(wide_n), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
